frame_feeder: RTL and testbench
===============================

FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the sample width popped from the framing FIFO.
REQ-002 SHALL have parameter FRAME_LEN_W, default 10, meaning log2 of the frame length (1024 samples).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, level request to stream frames.
REQ-006 SHALL have port fifo_rd_vld, input, 1, meaning the framing FIFO holds valid prefetched data.
REQ-007 SHALL have port fifo_rd_data, input, DATA_WIDTH, meaning the prefetched FIFO head sample.
REQ-008 SHALL have port fifo_rd_en, output, 1, pops the FIFO head in the same cycle.
REQ-009 SHALL have port m_data, output, 2*DATA_WIDTH, the FFT input word: {imag=0, real=sample}.
REQ-010 SHALL have port m_valid, output, 1, meaning m_data is valid.
REQ-011 SHALL have port m_ready, input, 1, meaning the FFT accepts data.
REQ-012 SHALL have port m_sof, output, 1, marking sample 0 of a frame.
REQ-013 SHALL have port m_last, output, 1, marking sample 2^FRAME_LEN_W-1 of a frame.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, STREAM and DRAIN.
REQ-016 In IDLE, enable=1 SHALL move the state to STREAM on the next edge, with the sample counter cleared to 0.
REQ-017 SHALL drive fifo_rd_en = fifo_rd_vld & (state==STREAM) & (~m_valid | m_ready), combinationally.
REQ-018 Each pop SHALL register the output stage on the next edge, with m_data={0, fifo_rd_data}, m_valid=1, m_sof=(cnt==0) and m_last=(cnt==max); latency is 1 cycle.
REQ-019 When m_valid=1 and m_ready=0, m_data, m_sof and m_last SHALL hold stable.
REQ-020 On an output handshake with no pop in the same cycle, m_valid SHALL clear.
REQ-021 The counter SHALL increment on each pop and wrap to 0 after max.
REQ-022 The pop of sample max SHALL move the state to DRAIN.
REQ-023 In DRAIN, the handshake of the m_last word SHALL move the state to IDLE.
REQ-024 FIFO underflow mid-frame (fifo_rd_vld=0) SHALL stall without padding and without dropping samples.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the current frame; the frame completes and the state then remains in IDLE.
REQ-026 Holding enable=1 SHALL start the next frame with one IDLE cycle between frames.
REQ-027 Pop and output handshake in the same cycle SHALL keep m_valid=1 with the new sample, at full throughput of 1 sample per cycle.

Reset
REQ-028 rst=1 SHALL asynchronously force the following: state=IDLE, cnt=0, m_valid=0, m_sof=0, m_last=0, m_data=0, busy=0.
REQ-029 rst asserted mid-frame SHALL discard the partial frame; the next frame restarts at sample 0.
REQ-030 fifo_rd_en SHALL be 0 during reset.

Configuration
REQ-031 With macro FRAME_FEEDER_FRAME_CNT_EN defined, the block SHALL add output frame_cnt, 16 bits.
REQ-032 frame_cnt SHALL reset to 0 and increment on each m_last handshake, wrapping from 0xFFFF to 0.
REQ-033 Without the macro, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario 1: enable=1, FIFO always valid, m_ready=1 -> 1024 consecutive m_valid cycles; m_sof on the first, m_last on the 1024th; m_data[15:0] equals the FIFO sequence and m_data[31:16]=0.
REQ-035 Scenario 2: m_ready toggling 1/0 each cycle -> no loss or duplication; the output holds stable on stall cycles; exactly 1024 handshakes per frame.
REQ-036 Scenario 3: fifo_rd_vld dropped for 5 cycles at sample 500 -> fifo_rd_en=0 for those cycles; samples 500 onward are contiguous once data resumes.
REQ-037 Scenario 4: enable dropped at sample 100 -> the frame still ends with m_last at sample 1023; busy=0 afterwards and no further pops.
REQ-038 Scenario 5: rst pulsed at sample 300 -> all outputs are 0 immediately; the next frame's first output has m_sof=1.
REQ-039 Scenario 6 (macro defined): 3 back-to-back frames -> frame_cnt=3, with a 1-cycle IDLE gap between frames.

Source files
------------

// File: rtl/frame_feeder.sv
// frame_feeder: streams 2^FRAME_LEN_W-sample frames from a prefetching FIFO into an FFT input port.
// Optional feature: define FRAME_FEEDER_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module frame_feeder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRAME_LEN_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sof,
    output logic                    m_last,
    output logic                    busy
`ifdef FRAME_FEEDER_FRAME_CNT_EN
    ,
    output logic [15:0]             frame_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    localparam logic [FRAME_LEN_W-1:0] CNT_MAX = '1;

    state_e                  state_q;
    logic [FRAME_LEN_W-1:0]  cnt_q;
    logic [2*DATA_WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    sof_q;
    logic                    last_q;
    logic                    pop;
    logic                    hs;

    // Pop only when the output register is empty or being drained this cycle.
    assign pop = fifo_rd_vld & (state_q == STREAM) & (~valid_q | m_ready);
    assign hs  = valid_q & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (pop) begin
                data_q  <= {{DATA_WIDTH{1'b0}}, fifo_rd_data};
                valid_q <= 1'b1;
                sof_q   <= (cnt_q == '0);
                last_q  <= (cnt_q == CNT_MAX);
                cnt_q   <= cnt_q + 1'b1;
            end else if (hs) begin
                valid_q <= 1'b0;
                sof_q   <= 1'b0;
                last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= STREAM;
                        cnt_q   <= '0;
                    end
                end
                STREAM: begin
                    if (pop && (cnt_q == CNT_MAX)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en = pop;
    assign m_data     = data_q;
    assign m_valid    = valid_q;
    assign m_sof      = sof_q;
    assign m_last     = last_q;
    assign busy       = (state_q != IDLE);

`ifdef FRAME_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (hs && last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_feeder.sv
// Scoreboard bench for frame_feeder: directed frames are queued as expected words,
// a negedge monitor pops and compares each presented output word.
module tb_frame_feeder;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_rd_vld;
    logic [15:0] head;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_last;
    logic        busy;
`ifdef FRAME_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [33:0] exp_q[$];
    bit          pop_seen = 1'b0;
    bit          toggle = 1'b0;
    bit          track_gap = 1'b0;
    bit          gap_arm = 1'b0;
    int          idle_run = 0;

    always #5 clk = ~clk;

    frame_feeder #(.DATA_WIDTH(16), .FRAME_LEN_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_rd_vld (fifo_rd_vld),
        .fifo_rd_data(head),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_last      (m_last),
        .busy        (busy)
`ifdef FRAME_FEEDER_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every presented word must match the queue head; it is popped only on handshake.
    always @(negedge clk) begin
        if (rst) begin
            pop_seen = 1'b0;
        end else begin
            pop_seen = fifo_rd_en;
            if (gap_arm) begin
                if (!busy) idle_run++;
                else begin
                    check("idle_gap", 64'(idle_run), 64'd1);
                    gap_arm  = 1'b0;
                    idle_run = 0;
                end
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none", m_data);
                end else begin
                    check("word", 64'({m_data, m_sof, m_last}), 64'(exp_q[0]));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        if (track_gap && m_last) gap_arm = 1'b1;
                    end
                end
            end
        end
    end

    // One clock step; the FIFO model advances its head on each pop seen in the previous cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (pop_seen) head = head + 16'd1;
        if (toggle) m_ready = ~m_ready;
    endtask

    task automatic push_frame(input logic [15:0] base);
        for (int i = 0; i < N; i++)
            exp_q.push_back({16'h0000, base + 16'(i), (i == 0), (i == N - 1)});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(n >= budget), 64'd0);
    endtask

    task automatic wait_head(input string name, input logic [15:0] target, input int budget);
        int n = 0;
        while (head != target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(n >= budget), 64'd0);
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({m_valid, m_sof, m_last, m_data, busy, fifo_rd_en}), 64'd0);
`ifdef FRAME_FEEDER_FRAME_CNT_EN
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic [15:0] base;
        int          n;
        int          pops;

        rst = 1'b1; enable = 1'b0; fifo_rd_vld = 1'b1; m_ready = 1'b1; head = 16'h1000;
        step();
        step();
        check_zero("reset_state");
        rst = 1'b0;
        step();

        // Three back-to-back frames at full rate; enable dropped inside the third.
        track_gap = 1'b1;
        base = head;
        push_frame(base);
        push_frame(base + 16'd1024);
        push_frame(base + 16'd2048);
        enable = 1'b1;
        n = 0;
        while (exp_q.size() > 1014 && n < 5000) begin
            step();
            n++;
        end
        check("s1_third_started", 64'(n >= 5000), 64'd0);
        enable = 1'b0;
        drain("s1_done", 3000);
        track_gap = 1'b0;
        gap_arm = 1'b0;
        idle_run = 0;
        check("s1_busy", 64'(busy), 64'd0);
        check("s1_head", 64'(head), 64'(base + 16'd3072));
`ifdef FRAME_FEEDER_FRAME_CNT_EN
        check("s6_frame_cnt", 64'(frame_cnt), 64'd3);
`endif

        // Ready toggling every cycle.
        toggle = 1'b1;
        push_frame(head);
        enable = 1'b1;
        step();
        enable = 1'b0;
        drain("s2_done", 3000);
        toggle = 1'b0;
        m_ready = 1'b1;

        // FIFO underflow for 5 cycles at sample 500.
        base = head;
        push_frame(base);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_head("s3_reach500", base + 16'd500, 2000);
        fifo_rd_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s3_no_pop", 64'(fifo_rd_en), 64'd0);
            step();
        end
        fifo_rd_vld = 1'b1;
        drain("s3_done", 2000);
        check("s3_head", 64'(head), 64'(base + 16'd1024));

        // Enable dropped at sample 100.
        base = head;
        push_frame(base);
        enable = 1'b1;
        wait_head("s4_reach100", base + 16'd100, 2000);
        enable = 1'b0;
        drain("s4_done", 2000);
        check("s4_busy", 64'(busy), 64'd0);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pops += int'(fifo_rd_en);
        end
        check("s4_no_more_pops", 64'(pops), 64'd0);
        check("s4_head", 64'(head), 64'(base + 16'd1024));

        // Reset mid-frame at sample 300.
        base = head;
        push_frame(base);
        enable = 1'b1;
        wait_head("s5_reach300", base + 16'd300, 2000);
        enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero("s5_reset_async");
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        push_frame(head);
        enable = 1'b1;
        step();
        enable = 1'b0;
        drain("s5_restart_done", 2000);
`ifdef FRAME_FEEDER_FRAME_CNT_EN
        check("s5_frame_cnt", 64'(frame_cnt), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
